// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register built as a 2-entry skid buffer (HEAD feeds MEM, SKID absorbs one
// extra beat), with branch-taken redirect pulse generation and a saturating MEM stall counter.
module ex_mem_skid_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_out,
    input  logic            ex_alu_zero,
    input  logic            ex_is_branch,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_alu_out,
    output logic [XLEN-1:0] mem_store_data,
    output logic [REGW-1:0] mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,
    output logic [2:0]      mem_funct3,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            redirect_misalign,
    output logic [CNTW-1:0] stall_cycles
);

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] store_data;
        logic [REGW-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
    } entry_t;

    entry_t          head_q, head_d, skid_q, skid_d, in_entry;
    logic            head_valid_q, head_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            ex_ready_q, ex_ready_d;
    logic            redir_valid_q, redir_valid_d;
    logic            redir_mis_q, redir_mis_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic [CNTW-1:0] stall_q, stall_d;
    logic            accept, drain, taken;

    assign in_entry = '{alu_out:    ex_alu_out,
                        store_data: ex_store_data,
                        rd:         ex_rd,
                        reg_write:  ex_reg_write,
                        mem_read:   ex_mem_read,
                        mem_write:  ex_mem_write,
                        funct3:     ex_funct3};

    assign accept = ex_valid & ex_ready_q & ~flush;
    assign drain  = head_valid_q & mem_ready;
    assign taken  = accept & ex_is_branch & ex_alu_zero;

    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // ex_ready is low whenever SKID is full, so no accept can coincide here
            if (drain) begin
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (!head_valid_q || drain) begin
            head_valid_d = accept;
            if (accept) head_d = in_entry;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_entry;
        end
        ex_ready_d = ~skid_valid_d;
    end

    always_comb begin
        redir_valid_d = taken;
        redir_pc_d    = redir_pc_q;
        redir_mis_d   = redir_mis_q;
        if (taken) begin
            redir_pc_d  = ex_target;
            redir_mis_d = |ex_target[1:0];
        end
        stall_d = stall_q;
        if (head_valid_q && !mem_ready && stall_q != {CNTW{1'b1}}) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q        <= '0;
            skid_q        <= '0;
            head_valid_q  <= 1'b0;
            skid_valid_q  <= 1'b0;
            ex_ready_q    <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            redir_mis_q   <= 1'b0;
            stall_q       <= '0;
        end else begin
            head_q        <= head_d;
            skid_q        <= skid_d;
            head_valid_q  <= head_valid_d;
            skid_valid_q  <= skid_valid_d;
            ex_ready_q    <= ex_ready_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            redir_mis_q   <= redir_mis_d;
            stall_q       <= stall_d;
        end
    end

    assign ex_ready          = ex_ready_q;
    assign mem_valid         = head_valid_q;
    assign mem_alu_out       = head_q.alu_out;
    assign mem_store_data    = head_q.store_data;
    assign mem_rd            = head_q.rd;
    assign mem_reg_write     = head_q.reg_write;
    assign mem_mem_read      = head_q.mem_read;
    assign mem_mem_write     = head_q.mem_write;
    assign mem_funct3        = head_q.funct3;
    assign redirect_valid    = redir_valid_q;
    assign redirect_pc       = redir_pc_q;
    assign redirect_misalign = redir_mis_q;
    assign stall_cycles      = stall_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: vector table for stream/back-pressure/branch cases,
// hand sequences for flush, counter saturation and asynchronous reset, payload scoreboard.
module tb_ex_mem_skid_stage;
    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 4;
    localparam int PW   = 75;

    logic            clk = 1'b0;
    logic            reset, flush, ex_valid, ex_alu_zero, ex_is_branch;
    logic [XLEN-1:0] ex_alu_out, ex_target, ex_store_data;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_mem_write;
    logic [2:0]      ex_funct3;
    logic            mem_ready;
    logic            ex_ready, mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [XLEN-1:0] mem_alu_out, mem_store_data, redirect_pc;
    logic [REGW-1:0] mem_rd;
    logic [2:0]      mem_funct3;
    logic            redirect_valid, redirect_misalign;
    logic [CNTW-1:0] stall_cycles;

    ex_mem_skid_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_out(ex_alu_out),
        .ex_alu_zero(ex_alu_zero), .ex_is_branch(ex_is_branch), .ex_target(ex_target),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_funct3(mem_funct3),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_misalign(redirect_misalign), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v, mr, fl, br, z;
        logic [XLEN-1:0] alu, tgt;
        logic            e_rdy, e_mv, e_rv, e_mis;
        logic [XLEN-1:0] e_pc;
        logic [CNTW-1:0] e_stall;
    } vec_t;

    int              n_checks = 0;
    int              n_fail   = 0;
    logic [PW-1:0]   sb_q[$];
    vec_t            vecs[16];

    function automatic vec_t mk(logic v, logic mr, logic fl, logic br, logic z,
                                logic [XLEN-1:0] alu, logic [XLEN-1:0] tgt,
                                logic e_rdy, logic e_mv, logic e_rv, logic e_mis,
                                logic [XLEN-1:0] e_pc, logic [CNTW-1:0] e_stall);
        vec_t t;
        t.v = v; t.mr = mr; t.fl = fl; t.br = br; t.z = z; t.alu = alu; t.tgt = tgt;
        t.e_rdy = e_rdy; t.e_mv = e_mv; t.e_rv = e_rv; t.e_mis = e_mis;
        t.e_pc = e_pc; t.e_stall = e_stall;
        return t;
    endfunction

    function automatic logic [PW-1:0] pay(logic [XLEN-1:0] a);
        return {a, a ^ 32'hFFFF_0000, a[4:0], a[0], a[1], a[2], a[5:3]};
    endfunction

    task automatic chk(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, ".ex_ready"},  PW'(ex_ready), '0);
        chk({tag, ".mem_valid"}, PW'(mem_valid), '0);
        chk({tag, ".mem_payload"},
            {mem_alu_out, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
             mem_mem_write, mem_funct3}, '0);
        chk({tag, ".redirect"}, PW'({redirect_valid, redirect_misalign, redirect_pc}), '0);
        chk({tag, ".stall"},     PW'(stall_cycles), '0);
    endtask

    task automatic step(vec_t t, string tag);
        @(negedge clk);
        ex_valid      = t.v;
        mem_ready     = t.mr;
        flush         = t.fl;
        ex_is_branch  = t.br;
        ex_alu_zero   = t.z;
        ex_target     = t.tgt;
        ex_alu_out    = t.alu;
        ex_store_data = t.alu ^ 32'hFFFF_0000;
        ex_rd         = t.alu[4:0];
        ex_reg_write  = t.alu[0];
        ex_mem_read   = t.alu[1];
        ex_mem_write  = t.alu[2];
        ex_funct3     = t.alu[5:3];
        #1;
        if (mem_valid && mem_ready) begin
            if (sb_q.size() == 0)
                chk({tag, ".sb_underflow"}, PW'(sb_q.size()), PW'(1));
            else
                chk({tag, ".mem_payload"},
                    {mem_alu_out, mem_store_data, mem_rd, mem_reg_write, mem_mem_read,
                     mem_mem_write, mem_funct3}, sb_q.pop_front());
        end
        if (flush) sb_q.delete();
        else if (ex_valid && ex_ready) sb_q.push_back(pay(ex_alu_out));
        @(posedge clk);
        #1;
        chk({tag, ".ex_ready"},  PW'(ex_ready), PW'(t.e_rdy));
        chk({tag, ".mem_valid"}, PW'(mem_valid), PW'(t.e_mv));
        chk({tag, ".redir_valid"}, PW'(redirect_valid), PW'(t.e_rv));
        chk({tag, ".redir_pc"},  PW'(redirect_pc), PW'(t.e_pc));
        chk({tag, ".redir_mis"}, PW'(redirect_misalign), PW'(t.e_mis));
        chk({tag, ".stall"},     PW'(stall_cycles), PW'(t.e_stall));
    endtask

    initial begin
        //            v  mr fl br z  alu       tgt        rdy mv rv mis pc         stall
        vecs[0]  = mk(1, 1, 0, 0, 0, 32'h1,    32'h0,     1, 1, 0, 0, 32'h0,     4'd0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 32'h2,    32'h0,     1, 1, 0, 0, 32'h0,     4'd0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 32'h3,    32'h0,     1, 1, 0, 0, 32'h0,     4'd0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 32'h0,    32'h0,     1, 0, 0, 0, 32'h0,     4'd0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 32'hA,    32'h0,     1, 1, 0, 0, 32'h0,     4'd0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 32'hB,    32'h0,     0, 1, 0, 0, 32'h0,     4'd1);
        vecs[6]  = mk(0, 0, 0, 0, 0, 32'h0,    32'h0,     0, 1, 0, 0, 32'h0,     4'd2);
        vecs[7]  = mk(0, 0, 0, 0, 0, 32'h0,    32'h0,     0, 1, 0, 0, 32'h0,     4'd3);
        vecs[8]  = mk(0, 1, 0, 0, 0, 32'h0,    32'h0,     1, 1, 0, 0, 32'h0,     4'd3);
        vecs[9]  = mk(0, 1, 0, 0, 0, 32'h0,    32'h0,     1, 0, 0, 0, 32'h0,     4'd3);
        vecs[10] = mk(1, 1, 0, 1, 1, 32'h20,   32'h100,   1, 1, 1, 0, 32'h100,   4'd3);
        vecs[11] = mk(0, 1, 0, 0, 0, 32'h0,    32'h0,     1, 0, 0, 0, 32'h100,   4'd3);
        vecs[12] = mk(1, 1, 0, 1, 0, 32'h21,   32'h200,   1, 1, 0, 0, 32'h100,   4'd3);
        vecs[13] = mk(0, 1, 0, 0, 0, 32'h0,    32'h0,     1, 0, 0, 0, 32'h100,   4'd3);
        vecs[14] = mk(1, 1, 0, 1, 1, 32'h2F,   32'h102,   1, 1, 1, 1, 32'h102,   4'd3);
        vecs[15] = mk(0, 1, 0, 0, 0, 32'h0,    32'h0,     1, 0, 0, 1, 32'h102,   4'd3);

        reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
        ex_alu_zero = 1'b0; ex_is_branch = 1'b0; ex_alu_out = '0; ex_target = '0;
        ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_funct3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset.ex_ready", PW'(ex_ready), PW'(1));

        for (int i = 0; i < 16; i++) step(vecs[i], $sformatf("vec%0d", i));

        // flush with HEAD+SKID full and a taken branch presented
        step(mk(1, 0, 0, 0, 0, 32'h55, 32'h0,   1, 1, 0, 1, 32'h102, 4'd3), "fl_fill0");
        step(mk(1, 0, 0, 0, 0, 32'h66, 32'h0,   0, 1, 0, 1, 32'h102, 4'd4), "fl_fill1");
        step(mk(1, 0, 1, 1, 1, 32'h67, 32'h300, 1, 0, 0, 1, 32'h102, 4'd5), "fl_full");
        // flush beats accept of a taken branch into an empty stage
        step(mk(1, 1, 1, 1, 1, 32'h68, 32'h304, 1, 0, 0, 1, 32'h102, 4'd5), "fl_empty");
        // flush coinciding with a drain: the entry still counts as consumed
        step(mk(1, 0, 0, 0, 0, 32'h77, 32'h0,   1, 1, 0, 1, 32'h102, 4'd5), "fl_drain0");
        step(mk(0, 1, 1, 0, 0, 32'h0,  32'h0,   1, 0, 0, 1, 32'h102, 4'd5), "fl_drain1");

        // stall counter saturates at all-ones
        step(mk(1, 0, 0, 0, 0, 32'h88, 32'h0,   1, 1, 0, 1, 32'h102, 4'd5), "sat_fill");
        for (int i = 0; i < 12; i++) begin
            automatic int e = (6 + i > 15) ? 15 : 6 + i;
            step(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 1, 32'h102, CNTW'(e)),
                 $sformatf("sat%0d", i));
        end
        step(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,   1, 0, 0, 1, 32'h102, 4'd15), "sat_drain");

        // asynchronous reset mid-stall with SKID full and a redirect pulse active
        step(mk(1, 0, 0, 0, 0, 32'h99, 32'h0,   1, 1, 0, 1, 32'h102, 4'd15), "ar_fill0");
        step(mk(1, 0, 0, 1, 1, 32'hAA, 32'h404, 0, 1, 1, 0, 32'h404, 4'd15), "ar_fill1");
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        step(mk(1, 1, 0, 0, 0, 32'hBB, 32'h0,   1, 1, 0, 0, 32'h0, 4'd0), "ar_after0");
        step(mk(0, 1, 0, 0, 0, 32'h0,  32'h0,   1, 0, 0, 0, 32'h0, 4'd0), "ar_after1");

        chk("sb_empty", PW'(sb_q.size()), PW'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
